// File: rtl/reverse_double_dabble_pkg.sv
// Shared BCD digit constants and a digit validity helper for the BCD-to-binary converter.
package reverse_double_dabble_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

  function automatic logic digit_is_valid(input logic [DIGIT_W-1:0] digit);
    return (digit <= BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/reverse_double_dabble_digit_adjust.sv
// Per-digit correction applied after each right shift: values of 8 or more lose 3.
module bcd_digit_adjust
  import reverse_double_dabble_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/reverse_double_dabble.sv
// Sequential BCD-to-binary converter using the shift-right / subtract-3 algorithm.
// Handshake: Start_i is taken only in IDLE; Done_o pulses one cycle with Binary_o/Error_o valid.
module reverse_double_dabble
  import reverse_double_dabble_pkg::*;
#(
  parameter int INPUT_DIGITS = 3,
  parameter int OUTPUT_BITS  = 10
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Start_i,
  input  logic [INPUT_DIGITS*4-1:0]   BCD_i,
  output logic [OUTPUT_BITS-1:0]      Binary_o,
  output logic                        Busy_o,
  output logic                        Done_o,
  output logic                        Error_o
);

  localparam int BCD_W  = INPUT_DIGITS * DIGIT_W;
  localparam int WORK_W = BCD_W + OUTPUT_BITS;
  localparam int CNT_W  = $clog2(OUTPUT_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUTPUT_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WORK_W-1:0]      work_q, work_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUTPUT_BITS-1:0] bin_q, bin_d;
  logic                   err_q, err_d;

  logic [WORK_W-1:0]      shifted;
  logic [BCD_W-1:0]       adj_bcd;
  logic [WORK_W-1:0]      adj_work;
  logic                   bcd_ok;

  assign shifted = work_q >> 1;

  for (genvar g = 0; g < INPUT_DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adjust (
      .digit_i (shifted[OUTPUT_BITS + g*DIGIT_W +: DIGIT_W]),
      .digit_o (adj_bcd[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign adj_work = {adj_bcd, shifted[OUTPUT_BITS-1:0]};

  always_comb begin
    bcd_ok = 1'b1;
    for (int d = 0; d < INPUT_DIGITS; d++) begin
      if (!digit_is_valid(BCD_i[d*DIGIT_W +: DIGIT_W])) bcd_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (Start_i) begin
          if (bcd_ok) begin
            work_d  = {BCD_i, {OUTPUT_BITS{1'b0}}};
            cnt_d   = '0;
            state_d = S_CONVERT;
          end else begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_CONVERT: begin
        work_d = adj_work;
        cnt_d  = cnt_q + 1'b1;
        // Binary field is complete once the last shift has landed.
        if (cnt_q == CNT_LAST) begin
          bin_d   = adj_work[OUTPUT_BITS-1:0];
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign Binary_o = bin_q;
  assign Error_o  = err_q;
  assign Busy_o   = (state_q == S_CONVERT);
  assign Done_o   = (state_q == S_DONE);

endmodule

// File: tb/tb_reverse_double_dabble.sv
// Directed and randomized bench for reverse_double_dabble against a decimal arithmetic model.
module tb_reverse_double_dabble;

  logic        Clock;
  logic        Reset;
  logic        Start_i;
  logic [11:0] BCD_i;
  logic [9:0]  Binary_o;
  logic        Busy_o;
  logic        Done_o;
  logic        Error_o;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];
  bit         err_q[$];

  reverse_double_dabble #(.INPUT_DIGITS(3), .OUTPUT_BITS(10)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start_i  (Start_i),
    .BCD_i    (BCD_i),
    .Binary_o (Binary_o),
    .Busy_o   (Busy_o),
    .Done_o   (Done_o),
    .Error_o  (Error_o)
  );

  // clock / reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference: decimal value of the digits, zero with error when any digit exceeds 9
  task automatic model(input logic [11:0] b, output int val, output bit err);
    val = 0;
    err = 1'b0;
    for (int d = 2; d >= 0; d--) begin
      int dig;
      dig = int'(b[d*4 +: 4]);
      if (dig > 9) err = 1'b1;
      val = val * 10 + dig;
    end
    if (err) val = 0;
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // driver: one conversion; optional second Start_i pulse after busy edge poke_at
  task automatic run_conv(input string tag, input logic [11:0] bcd,
                          input int poke_at, input logic [11:0] poke_bcd);
    int  val, edges, busy_cnt;
    bit  err, got;
    logic [9:0] exp_b;
    bit  exp_e;
    model(bcd, val, err);
    exp_q.push_back(10'(val));
    err_q.push_back(err);
    @(negedge Clock);
    Start_i = 1'b1;
    BCD_i   = bcd;
    edges = 0; busy_cnt = 0; got = 1'b0;
    while (!got && edges < 30) begin
      @(posedge Clock);
      #1;
      edges++;
      if (edges == 1) begin
        Start_i = 1'b0;
        BCD_i   = 12'($urandom);
      end
      if (poke_at > 0 && edges == poke_at + 1) begin
        Start_i = 1'b1;
        BCD_i   = poke_bcd;
      end else if (poke_at > 0 && edges == poke_at + 2) begin
        Start_i = 1'b0;
      end
      if (Busy_o) busy_cnt++;
      if (Done_o) got = 1'b1;
    end
    exp_b = exp_q.pop_front();
    exp_e = err_q.pop_front();
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(edges), err ? 32'd1 : 32'd11);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), err ? 32'd0 : 32'd10);
    check({tag, "_binary"}, 32'(Binary_o), 32'(exp_b));
    check({tag, "_error"}, 32'(Error_o), 32'(exp_e));
    @(posedge Clock);
    #1;
    check({tag, "_done_pulse_end"}, 32'(Done_o), 32'd0);
    check({tag, "_binary_hold"}, 32'(Binary_o), 32'(exp_b));
    check({tag, "_error_hold"}, 32'(Error_o), 32'(exp_e));
  endtask

  initial begin
    Reset   = 1'b0;
    Start_i = 1'b0;
    BCD_i   = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_binary", 32'(Binary_o), 32'd0);
    check("reset_busy",   32'(Busy_o),   32'd0);
    check("reset_done",   32'(Done_o),   32'd0);
    check("reset_error",  32'(Error_o),  32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    run_conv("zero", 12'h000, 0, 12'h0);
    run_conv("max999", 12'h999, 0, 12'h0);
    run_conv("invalid_1a3", 12'h1A3, 0, 12'h0);
    run_conv("after_err_042", 12'h042, 0, 12'h0);

    // second request during CONVERT must be ignored
    run_conv("ignore_255", 12'h255, 4, 12'h777);
    repeat (3) begin
      @(posedge Clock);
      #1;
      check("ignored_no_busy", 32'(Busy_o), 32'd0);
      check("ignored_no_done", 32'(Done_o), 32'd0);
    end
    check("ignored_binary_kept", 32'(Binary_o), 32'd255);

    // reset in the middle of a conversion
    @(negedge Clock);
    Start_i = 1'b1;
    BCD_i   = 12'h512;
    @(posedge Clock);
    #1;
    Start_i = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    check("pre_reset_busy", 32'(Busy_o), 32'd1);
    Reset = 1'b0;
    #1;
    check("midreset_binary", 32'(Binary_o), 32'd0);
    check("midreset_busy",   32'(Busy_o),   32'd0);
    check("midreset_done",   32'(Done_o),   32'd0);
    check("midreset_error",  32'(Error_o),  32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (14) begin
      @(posedge Clock);
      #1;
      check("aborted_no_done", 32'(Done_o), 32'd0);
    end
    run_conv("post_reset_128", 12'h128, 0, 12'h0);

    // random codes, valid and invalid digits mixed
    for (int i = 0; i < 40; i++) run_conv("random", 12'($urandom), 0, 12'h0);
    for (int i = 0; i < 20; i++)
      run_conv("random_valid", to_bcd(int'($urandom_range(0, 999))), 0, 12'h0);

    for (int i = 0; i <= 999; i++) run_conv("sweep_up", to_bcd(i), 0, 12'h0);
    for (int i = 999; i >= 0; i--) run_conv("sweep_down", to_bcd(i), 0, 12'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
